// File: rtl/mem_write_checker.sv
// mem_write_checker: on-chip PASS/FAIL/TIMEOUT monitor for the data-memory
// write bus. Latches the first illegal write and counts writes/cycles in RUN.
module mem_write_checker #(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 13,
    parameter int unsigned PASS_ADR    = 100,
    parameter int unsigned PASS_DATA   = 7,
    parameter int unsigned ALLOW_LO    = 96,
    parameter int unsigned ALLOW_HI    = 96,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  cyc_count
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    localparam logic [ADDR_W-1:0] PASS_ADR_C  = ADDR_W'(PASS_ADR);
    localparam logic [DATA_W-1:0] PASS_DATA_C = DATA_W'(PASS_DATA);
    localparam logic [ADDR_W-1:0] ALLOW_LO_C  = ADDR_W'(ALLOW_LO);
    localparam logic [ADDR_W-1:0] ALLOW_HI_C  = ADDR_W'(ALLOW_HI);
    localparam bit                TO_ENABLED  = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0]  TO_LAST     =
        CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   fail_adr_nxt;
    logic [DATA_W-1:0]   fail_data_nxt;
    logic [CNT_W-1:0]    wr_count_nxt, cyc_count_nxt;
    logic                active, pass_wr, legal_wr, to_hit;

    // State and status registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            fail_adr  <= '0;
            fail_data <= '0;
            wr_count  <= '0;
            cyc_count <= '0;
        end else begin
            state     <= state_nxt;
            fail_adr  <= fail_adr_nxt;
            fail_data <= fail_data_nxt;
            wr_count  <= wr_count_nxt;
            cyc_count <= cyc_count_nxt;
        end
    end

    // Classify the bus write and decide the next state and counter values.
    // The timeout edge leaves cyc_count at TIMEOUT_CYC-1; a terminating
    // PASS/FAIL write on that edge wins over the timeout.
    always_comb begin
        state_nxt     = state;
        fail_adr_nxt  = fail_adr;
        fail_data_nxt = fail_data;
        wr_count_nxt  = wr_count;
        cyc_count_nxt = cyc_count;
        active        = (state == ST_RUN) && en;
        pass_wr       = memwrite && (dataadr == PASS_ADR_C) && (writedata == PASS_DATA_C);
        legal_wr      = (dataadr >= ALLOW_LO_C) && (dataadr <= ALLOW_HI_C);
        to_hit        = TO_ENABLED && (cyc_count == TO_LAST);

        if (active) begin
            if (memwrite && (wr_count != '1)) begin
                wr_count_nxt = wr_count + 1'b1;
            end
            if (pass_wr) begin
                state_nxt = ST_PASS;
            end else if (memwrite && !legal_wr) begin
                state_nxt     = ST_FAIL;
                fail_adr_nxt  = dataadr;
                fail_data_nxt = writedata;
            end else if (to_hit) begin
                state_nxt = ST_TIMEOUT;
            end

            if (state_nxt != ST_TIMEOUT && cyc_count != '1) begin
                cyc_count_nxt = cyc_count + 1'b1;
            end
        end
    end

    // Status flags decode straight from the registered state.
    always_comb begin
        done    = (state != ST_RUN);
        pass    = (state == ST_PASS);
        fail    = (state == ST_FAIL);
        timeout = (state == ST_TIMEOUT);
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: a reference model pushes the
// expected outputs for each driven cycle into a queue, popped after the edge.
module tb_mem_write_checker;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic              done;
        logic              pass;
        logic              fail;
        logic              timeout;
        logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] fd;
        logic [CNT_W-1:0]  wr;
        logic [CNT_W-1:0]  cyc;
        logic              chk_cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic              memwrite = 1'b0;
    logic [ADDR_W-1:0] dataadr = '0;
    logic [DATA_W-1:0] writedata = '0;
    logic              done, pass, fail, timeout;
    logic [ADDR_W-1:0] fail_adr;
    logic [DATA_W-1:0] fail_data;
    logic [CNT_W-1:0]  wr_count, cyc_count;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t sb_q[$];

    // Reference model state: 0=RUN 1=PASS 2=FAIL 3=TIMEOUT
    int          m_st;
    int unsigned m_fa, m_fd, m_wr, m_cyc;

    mem_write_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PASS_ADR(100), .PASS_DATA(7),
        .ALLOW_LO(96), .ALLOW_HI(96), .TIMEOUT_CYC(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_adr(fail_adr), .fail_data(fail_data),
        .wr_count(wr_count), .cyc_count(cyc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit mw, input int unsigned a, input int unsigned d);
        bit term;
        if (r) begin
            m_st = 0; m_fa = 0; m_fd = 0; m_wr = 0; m_cyc = 0;
        end else if (e && m_st == 0) begin
            term = 0;
            if (mw) begin
                if (m_wr < 65535) m_wr++;
                if (a == 100 && d == 7) begin
                    m_st = 1; term = 1;
                end else if (!(a >= 96 && a <= 96)) begin
                    m_st = 2; m_fa = a; m_fd = d; term = 1;
                end
            end
            if (!term && m_cyc == 7) m_st = 3;
            else if (m_cyc < 65535) m_cyc++;
        end
    endtask

    // One clock: drive at negedge, push model expectation, compare after edge.
    task automatic step(input string name, input bit r, input bit e, input bit mw,
                        input int unsigned a, input int unsigned d);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; memwrite = mw;
        dataadr = ADDR_W'(a); writedata = DATA_W'(d);
        model(r, e, mw, a, d);
        x.done = (m_st != 0); x.pass = (m_st == 1); x.fail = (m_st == 2);
        x.timeout = (m_st == 3);
        x.fa = ADDR_W'(m_fa); x.fd = DATA_W'(m_fd);
        x.wr = CNT_W'(m_wr); x.cyc = CNT_W'(m_cyc);
        x.chk_cyc = (m_st == 0 || m_st == 3);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_assert++; n_fail++;
            $error("FAIL %s/scoreboard: observed empty expected entry", name);
        end else begin
            x = sb_q.pop_front();
            check({name, "/done"}, 32'(done), 32'(x.done));
            check({name, "/pass"}, 32'(pass), 32'(x.pass));
            check({name, "/fail"}, 32'(fail), 32'(x.fail));
            check({name, "/timeout"}, 32'(timeout), 32'(x.timeout));
            check({name, "/fail_adr"}, 32'(fail_adr), 32'(x.fa));
            check({name, "/fail_data"}, 32'(fail_data), 32'(x.fd));
            check({name, "/wr_count"}, 32'(wr_count), 32'(x.wr));
            if (x.chk_cyc) check({name, "/cyc_count"}, 32'(cyc_count), 32'(x.cyc));
        end
    endtask

    task automatic rst(input string name);
        step(name, 1, 0, 0, 0, 0);
    endtask

    initial begin
        m_st = 0; m_fa = 0; m_fd = 0; m_wr = 0; m_cyc = 0;

        // 1: legal scratch writes then the pass write; result holds
        rst("t1_rst0");
        rst("t1_rst1");
        step("t1_w96a", 0, 1, 1, 96, 3);
        step("t1_w96b", 0, 1, 1, 96, 5);
        step("t1_pass", 0, 1, 1, 100, 7);
        check("t1_pass_flag", 32'(pass), 32'd1);
        check("t1_wr3", 32'(wr_count), 32'd3);
        for (int i = 0; i < 10; i++) step("t1_hold", 0, 1, (i % 2) == 1, 80, 1);

        // 2: first illegal write is latched; later pass write ignored
        rst("t2_rst");
        step("t2_w96", 0, 1, 1, 96, 1);
        step("t2_w80", 0, 1, 1, 80, 9);
        check("t2_fail_adr", 32'(fail_adr), 32'd80);
        check("t2_fail_data", 32'(fail_data), 32'd9);
        step("t2_late_pass", 0, 1, 1, 100, 7);
        check("t2_wr2", 32'(wr_count), 32'd2);

        // 3: pass address with wrong data fails
        rst("t3_rst");
        step("t3_w100_6", 0, 1, 1, 100, 6);
        check("t3_fail_flag", 32'(fail), 32'd1);

        // 4a: timeout after 8 idle enabled edges, cyc_count left at 7
        rst("t4a_rst");
        for (int i = 0; i < 8; i++) step("t4a_idle", 0, 1, 0, 0, 0);
        check("t4a_timeout", 32'(timeout), 32'd1);
        check("t4a_cyc7", 32'(cyc_count), 32'd7);
        step("t4a_hold", 0, 1, 1, 100, 7);

        // 4b: pass write on the timeout edge wins
        rst("t4b_rst");
        for (int i = 0; i < 7; i++) step("t4b_idle", 0, 1, 0, 0, 0);
        step("t4b_pass", 0, 1, 1, 100, 7);
        check("t4b_pass_flag", 32'(pass), 32'd1);
        check("t4b_no_timeout", 32'(timeout), 32'd0);

        // 5: en low masks an illegal write, then pass
        rst("t5_rst");
        for (int i = 0; i < 5; i++) step("t5_masked", 0, 0, 1, 80, 1);
        step("t5_pass", 0, 1, 1, 100, 7);

        // 6: reset out of PASS, then a new failure
        rst("t6_rst");
        check("t6_cleared", 32'(done), 32'd0);
        step("t6_w81", 0, 1, 1, 81, 2);
        check("t6_fail_adr", 32'(fail_adr), 32'd81);

        // window edges: 95 and 97 are outside the [96,96] window
        rst("t7_rst");
        step("t7_w97", 0, 1, 1, 97, 4);
        rst("t8_rst");
        step("t8_w95", 0, 1, 1, 95, 12);
        check("t8_fail_data", 32'(fail_data), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
